cnn_layer_accel_sysmem_arb: RTL and testbench

Round-robin arbiter sharing one system-memory transaction port between C_NUM_REQ cnn_layer_accel_FAS instances. Each FAS has a read and a write request channel. The arbiter grants one transaction at a time and forwards the memory port's in-progress and completion status back to the granted FAS. It sits between the FAS array and the system memory controller.

---
 rtl/cnn_layer_accel_sysmem_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_cnn_layer_accel_sysmem_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_sysmem_arb.sv
// rtl/cnn_layer_accel_sysmem_arb.sv - round-robin arbiter sharing one system-memory port among FAS rd/wr channels
// Optional transfer watchdog enabled by defining SYSMEM_ARB_WDT_EN.
module cnn_layer_accel_sysmem_arb #(
    parameter int C_NUM_REQ    = 4,
    parameter int C_WDT_CYCLES = 1024
) (
    input  logic                                 clk_core,
    input  logic                                 rst,
    input  logic [C_NUM_REQ-1:0]                 fas_rd_req,
    output logic [C_NUM_REQ-1:0]                 fas_rd_req_ack,
    output logic [C_NUM_REQ-1:0]                 fas_rd_in_prog,
    output logic [C_NUM_REQ-1:0]                 fas_rd_cmpl,
    input  logic [C_NUM_REQ-1:0]                 fas_wr_req,
    output logic [C_NUM_REQ-1:0]                 fas_wr_req_ack,
    output logic [C_NUM_REQ-1:0]                 fas_wr_in_prog,
    output logic [C_NUM_REQ-1:0]                 fas_wr_cmpl,
    output logic                                 mem_req,
    output logic                                 mem_req_we,
    output logic [$clog2(C_NUM_REQ)-1:0]         mem_req_id,
    input  logic                                 mem_req_ack,
    input  logic                                 mem_in_prog,
    input  logic                                 mem_cmpl,
    output logic                                 busy,
    output logic                                 wdt_err
);

    localparam int C_ID_W  = $clog2(C_NUM_REQ);
    localparam int C_NSLOT = 2 * C_NUM_REQ;
    localparam int C_PTR_W = $clog2(C_NSLOT);

    if (C_NUM_REQ < 2 || C_NUM_REQ > 8) begin : g_bad_num_req
        $error("C_NUM_REQ out of range 2..8");
    end
    if (C_WDT_CYCLES < 2) begin : g_bad_wdt
        $error("C_WDT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_PTR_W-1:0]   ptr_q, ptr_d;
    logic [C_ID_W-1:0]    id_q, id_d;
    logic                 we_q, we_d;
    logic                 ack_q, ack_d;
    logic                 cmpl_q, cmpl_d;
    logic                 prog_q, prog_d;
    logic                 wdt_hit;

    logic [C_NSLOT-1:0]   slot_req;
    logic [C_NSLOT-1:0]   slot_rot;
    logic                 win_found;
    logic [C_PTR_W-1:0]   win_slot;
    logic [C_PTR_W:0]     win_sum;
    logic [C_NUM_REQ-1:0] id_oh;

    // Slot 2i is rd[i], slot 2i+1 is wr[i]
    always_comb begin
        slot_req = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            slot_req[2*i]   = fas_rd_req[i];
            slot_req[2*i+1] = fas_wr_req[i];
        end
    end

    // Rotate so bit 0 is the slot at the pointer; the first set bit wins
    always_comb begin
        slot_rot  = C_NSLOT'({slot_req, slot_req} >> ptr_q);
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = 0; k < C_NSLOT; k++) begin
            if (!win_found && slot_rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr_q} + (C_PTR_W+1)'(k);
            end
        end
        if (win_sum >= (C_PTR_W+1)'(C_NSLOT)) begin
            win_sum = win_sum - (C_PTR_W+1)'(C_NSLOT);
        end
        win_slot = win_sum[C_PTR_W-1:0];
    end

`ifdef SYSMEM_ARB_WDT_EN
    localparam int C_CNT_W = $clog2(C_WDT_CYCLES + 1);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               wdt_err_q, wdt_err_d;

    assign wdt_hit = ((state_q == S_ISSUE) || (state_q == S_XFER)) &&
                     (cnt_q == C_CNT_W'(C_WDT_CYCLES - 1));

    // Counter restarts on every state entry so ISSUE and XFER each get a full budget
    always_comb begin
        if ((state_d != state_q) ||
            !((state_q == S_ISSUE) || (state_q == S_XFER))) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
        wdt_err_d = wdt_err_q;
        if (wdt_hit && !mem_req_ack && !mem_cmpl) begin
            wdt_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            cnt_q     <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wdt_err_q <= wdt_err_d;
        end
    end

    assign wdt_err = wdt_err_q;
`else
    assign wdt_hit = 1'b0;
    assign wdt_err = 1'b0;
`endif

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ack) begin
                    state_d = mem_cmpl ? S_IDLE : S_XFER;
                end else if (wdt_hit) begin
                    state_d = S_DONE;
                end
            end
            S_XFER: begin
                if (mem_cmpl || wdt_hit) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant capture and registered status pulses; a real exit event beats the watchdog
    always_comb begin
        ptr_d  = ptr_q;
        id_d   = id_q;
        we_d   = we_q;
        ack_d  = 1'b0;
        cmpl_d = 1'b0;
        prog_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    id_d  = win_slot[C_PTR_W-1:1];
                    we_d  = win_slot[0];
                    ptr_d = (win_slot == C_PTR_W'(C_NSLOT - 1)) ? '0 : win_slot + C_PTR_W'(1);
                end
            end
            S_ISSUE: begin
                if (mem_req_ack) begin
                    ack_d  = 1'b1;
                    cmpl_d = mem_cmpl;
                end else if (wdt_hit) begin
                    cmpl_d = 1'b1;
                end
            end
            S_XFER: begin
                cmpl_d = mem_cmpl || wdt_hit;
                prog_d = mem_in_prog && !mem_cmpl && !wdt_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            ptr_q  <= '0;
            id_q   <= '0;
            we_q   <= 1'b0;
            ack_q  <= 1'b0;
            cmpl_q <= 1'b0;
            prog_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            id_q   <= id_d;
            we_q   <= we_d;
            ack_q  <= ack_d;
            cmpl_q <= cmpl_d;
            prog_q <= prog_d;
        end
    end

    always_comb begin
        id_oh          = {{(C_NUM_REQ-1){1'b0}}, 1'b1} << id_q;
        mem_req        = (state_q == S_ISSUE);
        mem_req_we     = mem_req ? we_q : 1'b0;
        mem_req_id     = mem_req ? id_q : '0;
        busy           = (state_q != S_IDLE);
        fas_rd_req_ack = (ack_q  && !we_q) ? id_oh : '0;
        fas_wr_req_ack = (ack_q  &&  we_q) ? id_oh : '0;
        fas_rd_cmpl    = (cmpl_q && !we_q) ? id_oh : '0;
        fas_wr_cmpl    = (cmpl_q &&  we_q) ? id_oh : '0;
        fas_rd_in_prog = (prog_q && !we_q) ? id_oh : '0;
        fas_wr_in_prog = (prog_q &&  we_q) ? id_oh : '0;
    end

endmodule

// File: tb/tb_cnn_layer_accel_sysmem_arb.sv
// tb/tb_cnn_layer_accel_sysmem_arb.sv - scoreboard bench for cnn_layer_accel_sysmem_arb
module tb_cnn_layer_accel_sysmem_arb;

    logic       clk_core = 1'b0;
    logic       rst;
    logic [3:0] fas_rd_req, fas_wr_req;
    logic [3:0] fas_rd_req_ack, fas_rd_in_prog, fas_rd_cmpl;
    logic [3:0] fas_wr_req_ack, fas_wr_in_prog, fas_wr_cmpl;
    logic       mem_req, mem_req_we;
    logic [1:0] mem_req_id;
    logic       mem_req_ack, mem_in_prog, mem_cmpl;
    logic       busy, wdt_err;
    logic [29:0] all_out;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    assign all_out = {fas_rd_req_ack, fas_rd_in_prog, fas_rd_cmpl,
                      fas_wr_req_ack, fas_wr_in_prog, fas_wr_cmpl,
                      mem_req, mem_req_we, mem_req_id, busy, wdt_err};

    cnn_layer_accel_sysmem_arb #(
        .C_NUM_REQ   (4),
        .C_WDT_CYCLES(16)
    ) dut (
        .clk_core      (clk_core),
        .rst           (rst),
        .fas_rd_req    (fas_rd_req),
        .fas_rd_req_ack(fas_rd_req_ack),
        .fas_rd_in_prog(fas_rd_in_prog),
        .fas_rd_cmpl   (fas_rd_cmpl),
        .fas_wr_req    (fas_wr_req),
        .fas_wr_req_ack(fas_wr_req_ack),
        .fas_wr_in_prog(fas_wr_in_prog),
        .fas_wr_cmpl   (fas_wr_cmpl),
        .mem_req       (mem_req),
        .mem_req_we    (mem_req_we),
        .mem_req_id    (mem_req_id),
        .mem_req_ack   (mem_req_ack),
        .mem_in_prog   (mem_in_prog),
        .mem_cmpl      (mem_cmpl),
        .busy          (busy),
        .wdt_err       (wdt_err)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] oh(input int id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    // Wait for mem_req, pop the expected slot and compare the granted id/we
    task automatic wait_grant(output int id, output logic we);
        int t;
        int slot;
        t = 0;
        while (mem_req !== 1'b1 && t < 64) begin
            @(negedge clk_core);
            t++;
        end
        check("mem_req_seen", {31'd0, mem_req}, 32'd1);
        slot = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
        id = slot >> 1;
        we = slot[0];
        check("grant_id", {30'd0, mem_req_id}, id);
        check("grant_we", {31'd0, mem_req_we}, {31'd0, we});
    endtask

    // ack_dly cycles of mem_req before ack; xfer_len 0 means ack and cmpl together
    task automatic txn(input int ack_dly, input int xfer_len);
        int   id;
        logic we;
        logic prev;
        wait_grant(id, we);
        repeat (ack_dly) begin
            @(negedge clk_core);
            check("mem_req_hold", {31'd0, mem_req}, 32'd1);
        end
        mem_req_ack = 1'b1;
        mem_cmpl    = (xfer_len == 0);
        @(negedge clk_core);
        mem_req_ack = 1'b0;
        mem_cmpl    = 1'b0;
        check("req_ack", we ? fas_wr_req_ack : fas_rd_req_ack, oh(id));
        check("req_ack_other", we ? fas_rd_req_ack : fas_wr_req_ack, 0);
        check("mem_req_drop", {31'd0, mem_req}, 0);
        if (we) fas_wr_req[id] = 1'b0;
        else    fas_rd_req[id] = 1'b0;
        if (xfer_len == 0) begin
            check("cmpl_with_ack", we ? fas_wr_cmpl : fas_rd_cmpl, oh(id));
            check("busy_after_ack_cmpl", {31'd0, busy}, 0);
        end else begin
            prev = 1'b0;
            for (int i = 0; i < xfer_len; i++) begin
                check("in_prog", we ? fas_wr_in_prog : fas_rd_in_prog, prev ? oh(id) : 4'b0);
                check("cmpl_early", {fas_rd_cmpl, fas_wr_cmpl}, 0);
                mem_in_prog = 1'($urandom_range(0, 1));
                prev        = mem_in_prog;
                mem_cmpl    = (i == xfer_len - 1);
                @(negedge clk_core);
            end
            check("cmpl", we ? fas_wr_cmpl : fas_rd_cmpl, oh(id));
            check("in_prog_clr", {fas_rd_in_prog, fas_wr_in_prog}, 0);
            check("busy_done", {31'd0, busy}, 1);
            mem_cmpl    = 1'b0;
            mem_in_prog = 1'b0;
            @(negedge clk_core);
            check("cmpl_pulse", {fas_rd_cmpl, fas_wr_cmpl}, 0);
            check("busy_idle", {31'd0, busy}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int   id;
        logic we;
        int   n;
        rst         = 1'b1;
        fas_rd_req  = '0;
        fas_wr_req  = '0;
        mem_req_ack = 1'b0;
        mem_in_prog = 1'b0;
        mem_cmpl    = 1'b0;
        repeat (3) @(negedge clk_core);
        check("reset_outputs", {2'd0, all_out}, 0);
        rst = 1'b0;
        @(negedge clk_core);

        // single read on id 2
        fas_rd_req[2] = 1'b1;
        exp_q.push_back(4);
        @(negedge clk_core);
        check("req_to_mem_req_latency", {31'd0, mem_req}, 1);
        txn(3, 10);

        // stray memory handshakes while idle
        mem_cmpl    = 1'b1;
        mem_req_ack = 1'b1;
        @(negedge clk_core);
        mem_cmpl    = 1'b0;
        mem_req_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stray_no_output", {2'd0, all_out}, 0);
            @(negedge clk_core);
        end

        // write on id 1 with ack and cmpl together
        fas_wr_req[1] = 1'b1;
        exp_q.push_back(3);
        txn(1, 0);
        @(negedge clk_core);
        check("no_regrant_after_drop", {31'd0, mem_req}, 0);
        check("idle_after_ack_cmpl", {31'd0, busy}, 0);

        // reset during a read transfer for id 3
        fas_rd_req[3] = 1'b1;
        exp_q.push_back(6);
        wait_grant(id, we);
        mem_req_ack = 1'b1;
        @(negedge clk_core);
        mem_req_ack   = 1'b0;
        fas_rd_req[3] = 1'b0;
        check("rst_txn_ack", fas_rd_req_ack, 4'b1000);
        mem_in_prog = 1'b1;
        repeat (3) @(negedge clk_core);
        check("rst_txn_in_prog", fas_rd_in_prog, 4'b1000);
        rst = 1'b1;
        @(negedge clk_core);
        check("rst_mid_xfer_outputs", {2'd0, all_out}, 0);
        rst         = 1'b0;
        mem_in_prog = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_core);
            check("rst_no_cmpl", fas_rd_cmpl, 0);
        end

        // fairness from a reset pointer: slots 0..7 then 0 again
        for (int s = 0; s < 9; s++) exp_q.push_back(s % 8);
        fas_rd_req = 4'hF;
        fas_wr_req = 4'hF;
        for (int i = 0; i < 9; i++) begin
            txn(1, 2);
            if (i < 8) begin
                if ((i % 2) == 1) fas_wr_req[i / 2] = 1'b1;
                else              fas_rd_req[i / 2] = 1'b1;
            end else begin
                fas_rd_req = '0;
                fas_wr_req = '0;
            end
        end

        // transfer whose completion never arrives
        fas_rd_req[0] = 1'b1;
        exp_q.push_back(0);
        wait_grant(id, we);
        mem_req_ack = 1'b1;
        @(negedge clk_core);
        mem_req_ack   = 1'b0;
        fas_rd_req[0] = 1'b0;
        check("wdt_txn_ack", fas_rd_req_ack, 4'b0001);
`ifdef SYSMEM_ARB_WDT_EN
        n = 0;
        while (fas_rd_cmpl[0] !== 1'b1 && n < 100) begin
            @(negedge clk_core);
            n++;
        end
        check("wdt_xfer_cycles", n, 16);
        check("wdt_err_set", {31'd0, wdt_err}, 1);
        fas_rd_req[1] = 1'b1;
        exp_q.push_back(2);
        txn(2, 3);
        check("wdt_err_sticky", {31'd0, wdt_err}, 1);
`else
        n = 0;
        repeat (40) begin
            @(negedge clk_core);
            n++;
        end
        check("no_wdt_busy", {31'd0, busy}, 1);
        check("no_wdt_err", {31'd0, wdt_err}, 0);
        check("no_wdt_cmpl", fas_rd_cmpl, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
